// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, parity modes and frame sizing shared by the UART transmitter and receiver.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, ARM, START, DATA, PAR, STOP} uart_state_e;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + int'(parity != PAR_NONE) + stop_bits;
  endfunction
endpackage

// File: rtl/uart_parity_gen.sv
// uart_parity_gen: XOR reduction of a data word, inverted for odd parity.
module uart_parity_gen #(
  parameter int W = 8
) (
  input  logic [W-1:0] data,
  input  logic         odd,
  output logic         par
);
  assign par = ^data ^ odd;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART frame serializer, one bit per baud_tick, valid/ready word input, registered tx line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < PAR_NONE || PARITY > PAR_ODD || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_tx: illegal DATA_BITS/PARITY/STOP_BITS");
  end
  uart_state_e state, state_nxt;
  logic [DATA_BITS-1:0] sh, sh_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic stp, stp_nxt, par_q, par_nxt, par_w, tx_nxt;
  uart_parity_gen #(.W(DATA_BITS)) u_par (
    .data(tx_data),
    .odd (PARITY == PAR_ODD),
    .par (par_w)
  );
  assign tx_ready = state == IDLE;
  assign busy = !tx_ready;
  always_ff @(posedge clk_in)
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      stp   <= 1'b0;
      par_q <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_nxt;
      sh    <= sh_nxt;
      cnt   <= cnt_nxt;
      stp   <= stp_nxt;
      par_q <= par_nxt;
      tx    <= tx_nxt;
    end
  // ARM absorbs the handshake-cycle tick so the start bit is always a full interval
  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = cnt;
    stp_nxt   = stp;
    par_nxt   = par_q;
    case (state)
      IDLE: if (tx_valid) begin
        state_nxt = ARM;
        sh_nxt    = tx_data;
        par_nxt   = par_w;
      end
      ARM: if (baud_tick) state_nxt = START;
      START: if (baud_tick) begin
        state_nxt = DATA;
        cnt_nxt   = '0;
      end
      DATA: if (baud_tick) begin
        sh_nxt = sh >> 1;
        if (cnt == LAST) begin
          state_nxt = (PARITY != PAR_NONE) ? PAR : STOP;
          stp_nxt   = 1'b0;
        end else cnt_nxt = cnt + 1'b1;
      end
      PAR: if (baud_tick) begin
        state_nxt = STOP;
        stp_nxt   = 1'b0;
      end
      STOP: if (baud_tick) begin
        if (stp == STOP_LAST) state_nxt = IDLE;
        else stp_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    tx_nxt = state_nxt == START ? 1'b0 :
             state_nxt == DATA  ? sh_nxt[0] :
             state_nxt == PAR   ? par_nxt : 1'b1;
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter stage that consumes the baud timing produced by the baud-rate generator and turns parallel bytes into an asynchronous UART frame on `tx`. It runs entirely in the `clk_in` domain and advances one bit per `baud_tick` strobe. Upstream logic hands it words through a valid/ready handshake.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal range 5–9.
- `PARITY`, 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

- `clk_in`  in  1  system clock. This is the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `baud_tick`  in  1  one-`clk_in`-cycle strobe, one per bit period, from the baud generator.
- `tx_data`  in  DATA_BITS  word to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  block can accept a word. Equals `state == IDLE`.
- `tx`  out  1  serial line. Registered. Idles high.
- `busy`  out  1  frame in progress, i.e. `!tx_ready`.

## Operation
- FSM states: `IDLE`, `ARM`, `START`, `DATA`, `PAR`, `STOP`.
- **IDLE**
  - `tx` = 1.
  - Handshake fires when `tx_valid && tx_ready`.
  - On the handshake: latch `tx_data` into the shift register, compute parity, go to `ARM`.
- **ARM**
  - `tx` = 1.
  - On `baud_tick`: go to `START`.
- **START**
  - `tx` = 0.
  - On `baud_tick`: go to `DATA`, bit counter = 0.
- **DATA**
  - `tx` = shift register bit 0. Data is sent LSB first.
  - On `baud_tick`: shift right and increment the counter.
  - After bit `DATA_BITS-1`, go to `PAR` if `PARITY != 0`, otherwise to `STOP`.
- **PAR**
  - `tx` = parity bit. Even mode: XOR of the latched data. Odd mode: its inverse.
  - On `baud_tick`: go to `STOP`.
- **STOP**
  - `tx` = 1.
  - Lasts `STOP_BITS` tick intervals, then go to `IDLE`.
- Changes on `tx_data` / `tx_valid` after the handshake have no effect on the frame in flight.
- `baud_tick` is ignored in `IDLE`.
- Parameter values outside the legal ranges are a compile-time error (elaboration assertion).

## Timing
- Reset values: state = `IDLE`, `tx` = 1, `tx_ready` = 1, `busy` = 0, shift register = 0, counters = 0.
- Reset takes effect on the first `clk_in` edge with `rst` high.
- Reset mid-frame: the frame is abandoned and `tx` is 1 in the cycle after that edge. No partial stop bit is appended.
- `tx` is registered. A tick sampled at edge N changes `tx` after edge N.
- Bit period:
  - Every bit, including the start bit, is exactly one tick interval wide.
  - The `ARM` state guarantees a full-width start bit regardless of handshake phase.
- Tick coincident with the handshake cycle: that tick is not used. The start bit begins at the next tick.
- Latency, handshake to falling edge of `tx`: 1 cycle plus the wait for the next tick. At most one tick interval plus 1 cycle.
- Frame length, in tick intervals: 1 + `DATA_BITS` + (`PARITY != 0`) + `STOP_BITS`.
- `tx_ready` rises in the cycle after the final stop tick.
  - A new word may be accepted that same cycle.
  - Back-to-back frames therefore include one `ARM` wait. Stop-bit width is always at least the nominal width.
- Ticks spaced one cycle apart (every cycle) are legal. Each tick advances exactly one bit.
- Bit counter width: `$clog2(DATA_BITS)`, saturating at the `DATA` exit. The stop counter is 1 bit.

## Structure
- Shared package `uart_pkg`. Shared with the future receiver. Contents:
  - state enum `uart_state_e`;
  - parity constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`;
  - frame-length helper function.
- One sub-module is natural: `uart_parity_gen`. Combinational XOR reduction with even/odd select, reused by the receiver.
- Rest: single FSM `always` block plus shift register in `uart_tx`.

## Test plan
- `baud_tick` every 4 cycles, defaults, send 0x55 → `tx` = 1, then 0, then 1,0,1,0,1,0,1,0, then 1. Each level held 4 cycles. `tx_ready` returns high 1 cycle after the stop tick.
- `PARITY`=1, send 0xA3 → data bits 1,1,0,0,0,1,0,1, parity bit 0. With `PARITY`=2, the same word gives parity bit 1.
- Handshake in the same cycle as `baud_tick` → `tx` stays 1 through that tick and falls only after the following tick. The start bit is a full 4 cycles.
- `STOP_BITS`=2, back-to-back words 0x00 then 0xFF with `tx_valid` held high → `tx` high for at least 2 tick intervals between frames. The second frame reads LSB-first 1,1,1,1,1,1,1,1. No handshake is lost.
- Assert `rst` for 1 cycle during data bit 3 of 0x0F → next cycle: `tx` = 1, `tx_ready` = 1, `busy` = 0. The following word 0x81 is transmitted correctly.
- Ticks every cycle, `DATA_BITS`=5, send 0x1F → frame is exactly 7 tick intervals after `ARM`, and `tx` bits match 0,1,1,1,1,1,1.
